mux_tree_pipe: RTL
==================

# mux_tree_pipe

Parametrised, pipelined N:1 multiplexer tree built from 2:1 stages, with one register per tree level. It carries the select and a valid flag alongside the data, supports a global hold, and has an auto-scan mode in which an internal counter walks the select through all N channels. It sits between wide multi-channel sample sources and a single downstream consumer, where the combinational N:1 tree no longer meets timing.

## Interface
- N, 8: number of input channels; power of two, N >= 2.
- W, 1: width of each channel, in bits.
- L (derived, not overridable): log2(N), the number of tree levels and the latency in enabled cycles.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- in  in  N*W  channel c occupies bits [c*W +: W].
- sel  in  L  channel select, used when auto_en=0.
- in_valid  in  1  qualifies in and sel for this cycle.
- en  in  1  pipeline advance; when 0, all state holds.
- auto_en  in  1  1 = select comes from the internal scan counter and sel is ignored.
- out  out  W  selected channel data.
- out_sel  out  L  channel index that produced out.
- out_valid  out  1  out and out_sel are valid.

## Operation
- The tree has L levels. Level k (k=0 is the input side) is a bank of N/2^(k+1) 2:1 muxes. Each mux at level k is steered by bit k of the effective select: 0 passes the even input, 1 passes the odd input.
- Each level ends in a register stage that holds:
  - the mux outputs;
  - the still-unused select bits [L-1:k+1];
  - the full effective select, for out_sel;
  - the valid bit.
- Effective select:
  - auto_en=0: sel.
  - auto_en=1: scan_cnt.
- scan_cnt is an internal L-bit counter:
  - reset value 0;
  - forced to 0 on every enabled cycle with auto_en=0;
  - increments on each cycle with auto_en=1, en=1 and in_valid=1;
  - wraps from N-1 to 0.
  - Consequence: every entry into auto mode starts at channel 0.
- en=0:
  - all pipeline registers, valids and scan_cnt hold;
  - in, sel and in_valid are ignored;
  - outputs stay stable.
- in_valid=0 with en=1 inserts a bubble. The bubble advances like data, and its data/sel contents are don't-care.
- Toggling auto_en mid-stream affects only samples entering on or after the toggle cycle. Samples already in flight keep their select.

## Timing
- Latency: a sample accepted on an enabled edge appears on out/out_sel/out_valid exactly L enabled edges later. Disabled cycles do not count.
- Throughput: one sample per enabled cycle, with no gaps required.
- Reset (asynchronous assert, any cycle, including mid-stream):
  - all valid bits, out, out_sel and scan_cnt clear to 0 immediately;
  - out_valid=0 until L enabled edges after the first accepted sample following deassertion.
- Outputs are registered. There is no combinational path from any input to any output.
- N=2: a single level, latency 1.

## Test plan
- Manual select, N=8, W=4, in channel c = c+1 (0x1..0x8), en=1: present sel=5 with in_valid=1 for one cycle.
  - Required: out=0x6, out_sel=5, out_valid=1 exactly 3 cycles later, for one cycle.
- Back-to-back stream, same setup: sel sequence 0,7,3,3,6, one per cycle, in_valid=1.
  - Required: out 0x1,0x8,0x4,0x4,0x7 on consecutive cycles starting at cycle 3.
  - Required: a bubble (in_valid=0) at position 3 yields out_valid=0 in the matching output slot only.
- Auto scan: auto_en=1, in_valid=1 for 10 cycles.
  - Required: out_sel 0,1,...,7,0,1.
  - Required: drop auto_en for one cycle and re-raise it; the next auto sample has out_sel=0.
- Hold: while a sample is at level 1, drive en=0 for 4 cycles.
  - Required: out, out_sel, out_valid and scan_cnt are unchanged during the hold.
  - Required: the sample emerges after the remaining 2 enabled cycles with correct data.
- Reset mid-stream: assert rst_n=0 asynchronously between edges while 3 samples are in flight.
  - Required: out_valid=0, out=0 and out_sel=0 immediately.
  - Required: after release, the first new sample appears 3 cycles after acceptance and no stale sample is ever emitted.
- Parameter sweep: N=2, W=1 and N=16, W=8, with a random sel/in_valid/en/auto_en stream checked against a reference model.
  - Required: latency is L enabled edges, and out matches in[out_sel*W +: W] sampled at acceptance.

Source files
------------

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 multiplexer tree built from 2:1 stages, one register per level.
// The effective select and a valid flag travel alongside the data. en=0 freezes
// every register. With auto_en=1 an internal counter replaces sel and steps
// through the channels once per accepted sample.
module mux_tree_pipe #(
   parameter int N = 8,
   parameter int W = 1,
   localparam int L = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N*W-1:0] in,
   input  logic [L-1:0]   sel,
   input  logic           in_valid,
   input  logic           en,
   input  logic           auto_en,
   output logic [W-1:0]   out,
   output logic [L-1:0]   out_sel,
   output logic           out_valid
);

   // Tree storage is one flat vector. Level k holds N>>(k+1) entries and starts
   // at entry N - (N>>k), so the single entry of the last level is entry N-2.
   logic [(N-1)*W-1:0] tree_reg;
   logic [(N-1)*W-1:0] tree_next;
   logic [L-1:0]       sel_reg [L];
   logic [L-1:0]       valid_reg;
   logic [L-1:0]       scan_cnt;
   logic [L-1:0]       eff_sel;
   logic [L-1:0]       step_sel;

   assign eff_sel = auto_en ? scan_cnt : sel;

   generate
      for (genvar gi = 0; gi < L; gi++) begin : g_level
         localparam int OFF = N - (N >> gi);
         localparam int CNT = N >> (gi + 1);

         // Level 0 is steered by the incoming select; later levels by the copy
         // of the select that travelled with their data.
         if (gi == 0) begin : g_sel_in
            assign step_sel[gi] = eff_sel[0];
         end else begin : g_sel_pipe
            assign step_sel[gi] = sel_reg[gi-1][gi];
         end

         for (genvar gj = 0; gj < CNT; gj++) begin : g_mux
            if (gi == 0) begin : g_from_in
               assign tree_next[(OFF+gj)*W +: W] = step_sel[gi] ?
                  in[(2*gj+1)*W +: W] : in[(2*gj)*W +: W];
            end else begin : g_from_tree
               localparam int POFF = N - (N >> (gi - 1));
               assign tree_next[(OFF+gj)*W +: W] = step_sel[gi] ?
                  tree_reg[(POFF+2*gj+1)*W +: W] : tree_reg[(POFF+2*gj)*W +: W];
            end
         end
      end
   endgenerate

   // Pipeline registers: data, select copy and valid advance together on en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tree_reg  <= '0;
         valid_reg <= '0;
         for (int i = 0; i < L; i++) begin
            sel_reg[i] <= '0;
         end
      end else if (en) begin
         tree_reg     <= tree_next;
         valid_reg[0] <= in_valid;
         sel_reg[0]   <= eff_sel;
         for (int i = 1; i < L; i++) begin
            valid_reg[i] <= valid_reg[i-1];
            sel_reg[i]   <= sel_reg[i-1];
         end
      end
   end

   // Scan counter: restarts at channel 0 whenever manual mode is seen, steps on
   // each accepted auto sample and wraps naturally at N (power of two).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
      end else if (en) begin
         if (!auto_en) begin
            scan_cnt <= '0;
         end else if (in_valid) begin
            scan_cnt <= scan_cnt + L'(1);
         end
      end
   end

   assign out       = tree_reg[(N-2)*W +: W];
   assign out_sel   = sel_reg[L-1];
   assign out_valid = valid_reg[L-1];

endmodule
